// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader: pops FIFO words on a step edge or pacing tick and holds the last word
module sync_fifo_reader #(
  parameter int          DATA_WIDTH = 4,
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int          CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  input  logic                  auto_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_re,
  output logic [DATA_WIDTH-1:0] data_hold,
  output logic                  hold_valid,
  output logic [CNT_WIDTH-1:0]  pop_cnt,
  output logic                  underflow,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, READ, CAPTURE} state_t;
  state_t                state_q, state_d;
  logic                  step_q;
  logic [31:0]           cnt_q, cnt_d;
  logic                  tick, req;
  logic                  fifo_re_q, fifo_re_d;
  logic [DATA_WIDTH-1:0] data_hold_q, data_hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [CNT_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;
  logic                  underflow_q, underflow_d;
  // pacing counter wraps at TICK_DIV-1 and is held at zero while auto mode is off
  always_comb begin
    tick  = auto_en && (cnt_q == TICK_DIV - 1);
    cnt_d = (!auto_en || tick) ? '0 : cnt_q + 32'd1;
    req   = (step && !step_q) || tick;
  end
  // next state: requests only matter in IDLE and only start a read when data is present
  always_comb begin
    state_d = (state_q == IDLE) ? ((req && !fifo_empty) ? READ : IDLE) :
              (state_q == READ) ? CAPTURE : IDLE;
  end
  // outputs: read strobe tracks READ; capture happens the cycle after the strobe
  always_comb begin
    fifo_re_d    = (state_d == READ);
    data_hold_d  = (state_q == CAPTURE) ? fifo_dout : data_hold_q;
    hold_valid_d = hold_valid_q || (state_q == CAPTURE);
    pop_cnt_d    = (state_q == CAPTURE) ? pop_cnt_q + CNT_WIDTH'(1) : pop_cnt_q;
    underflow_d  = underflow_q || (state_q == IDLE && req && fifo_empty);
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      step_q       <= 1'b0;
      cnt_q        <= '0;
      fifo_re_q    <= 1'b0;
      data_hold_q  <= '0;
      hold_valid_q <= 1'b0;
      pop_cnt_q    <= '0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step;
      cnt_q        <= cnt_d;
      fifo_re_q    <= fifo_re_d;
      data_hold_q  <= data_hold_d;
      hold_valid_q <= hold_valid_d;
      pop_cnt_q    <= pop_cnt_d;
      underflow_q  <= underflow_d;
    end
  end
  assign fifo_re    = fifo_re_q;
  assign data_hold  = data_hold_q;
  assign hold_valid = hold_valid_q;
  assign pop_cnt    = pop_cnt_q;
  assign underflow  = underflow_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_sync_fifo_reader.sv
// tb_sync_fifo_reader: directed checks of sync_fifo_reader against a small FIFO model
module tb_sync_fifo_reader;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       step = 1'b0;
  logic       auto_en = 1'b0;
  logic       fifo_empty;
  logic [3:0] fifo_dout = 4'h0;
  logic       fifo_re;
  logic [3:0] data_hold;
  logic       hold_valid;
  logic [7:0] pop_cnt;
  logic       underflow;
  logic       busy;
  int total = 0;
  int bad = 0;
  logic [3:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc = 0;
  int re_pulses = 0;
  int re_consec = 0;
  int re_prev_cyc = 0;
  int re_last_cyc = 0;
  logic re_prev = 1'b0;

  sync_fifo_reader #(.DATA_WIDTH(4), .TICK_DIV(5), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .step(step), .auto_en(auto_en),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_re(fifo_re),
    .data_hold(data_hold), .hold_valid(hold_valid), .pop_cnt(pop_cnt),
    .underflow(underflow), .busy(busy)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  // FIFO model: dout valid the cycle after re is sampled; also monitors strobe shape
  always @(posedge clk) begin
    cyc <= cyc + 1;
    re_prev <= fifo_re;
    if (fifo_re) begin
      fifo_dout <= mem[rd_ptr % 16];
      rd_ptr <= rd_ptr + 1;
      re_pulses <= re_pulses + 1;
      re_prev_cyc <= re_last_cyc;
      re_last_cyc <= cyc;
      if (re_prev) re_consec <= re_consec + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] v);
    mem[wr_ptr % 16] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_step(input int gap);
    step = 1'b1;
    wait_n(1);
    step = 1'b0;
    wait_n(gap);
  endtask

  initial begin
    wait_n(3);
    check("rst_re", fifo_re, 0);
    check("rst_hold", data_hold, 0);
    check("rst_valid", hold_valid, 0);
    check("rst_cnt", pop_cnt, 0);
    check("rst_unf", underflow, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    wait_n(2);
    // manual pops of 3, 9, C
    push(4'h3); push(4'h9); push(4'hC);
    step = 1'b1;
    wait_n(1);
    check("man_re_lat", fifo_re, 1);
    check("man_busy", busy, 1);
    step = 1'b0;
    wait_n(1);
    check("man_re_one", fifo_re, 0);
    wait_n(1);
    check("man_hold1", data_hold, 4'h3);
    wait_n(7);
    pulse_step(9);
    check("man_hold2", data_hold, 4'h9);
    pulse_step(9);
    check("man_hold3", data_hold, 4'hC);
    check("man_cnt", pop_cnt, 3);
    check("man_valid", hold_valid, 1);
    check("man_unf", underflow, 0);
    check("man_pulses", re_pulses, 3);
    // auto mode at TICK_DIV=5: four pops then an underflow on the fifth tick
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    auto_en = 1'b1;
    wait_n(24);
    check("auto_cnt", pop_cnt, 7);
    check("auto_hold", data_hold, 4'h4);
    check("auto_unf0", underflow, 0);
    check("auto_spacing", re_last_cyc - re_prev_cyc, 5);
    check("auto_pulses", re_pulses, 7);
    wait_n(1);
    check("auto_unf1", underflow, 1);
    auto_en = 1'b0;
    wait_n(3);
    // step on empty FIFO
    step = 1'b1;
    wait_n(1);
    check("empty_re", fifo_re, 0);
    check("empty_unf", underflow, 1);
    step = 1'b0;
    wait_n(9);
    check("empty_cnt", pop_cnt, 7);
    check("empty_hold", data_hold, 4'h4);
    push(4'h5);
    pulse_step(9);
    check("after_hold", data_hold, 4'h5);
    check("after_cnt", pop_cnt, 8);
    check("after_unf", underflow, 1);
    // step held high for 50 cycles pops once
    push(4'h6); push(4'h7);
    step = 1'b1;
    wait_n(50);
    step = 1'b0;
    wait_n(5);
    check("held_cnt", pop_cnt, 9);
    check("held_hold", data_hold, 4'h6);
    // a second edge landing in CAPTURE is dropped
    step = 1'b1;
    wait_n(1);
    step = 1'b0;
    wait_n(1);
    step = 1'b1;
    wait_n(1);
    step = 1'b0;
    wait_n(10);
    check("drop_cnt", pop_cnt, 10);
    check("drop_hold", data_hold, 4'h7);
    check("drop_empty", fifo_empty, 1);
    // run pop_cnt up to 255, then wrap
    for (int i = 0; i < 245; i++) begin
      push(4'(i));
      pulse_step(3);
    end
    check("pre_wrap_cnt", pop_cnt, 255);
    push(4'hA);
    pulse_step(9);
    check("wrap_cnt", pop_cnt, 0);
    check("wrap_hold", data_hold, 4'hA);
    // asynchronous reset during READ
    push(4'hB);
    step = 1'b1;
    wait_n(1);
    check("mid_re_hi", fifo_re, 1);
    #2;
    rst = 1'b0;
    step = 1'b0;
    #1;
    check("mid_re_lo", fifo_re, 0);
    check("mid_busy", busy, 0);
    check("mid_hold", data_hold, 0);
    check("mid_cnt", pop_cnt, 0);
    check("mid_unf", underflow, 0);
    check("mid_valid", hold_valid, 0);
    #1;
    rst = 1'b1;
    wait_n(3);
    pulse_step(9);
    check("post_hold", data_hold, 4'hB);
    check("post_cnt", pop_cnt, 1);
    check("post_valid", hold_valid, 1);
    check("post_unf", underflow, 0);
    check("total_pulses", re_pulses, 257);
    check("no_consec_re", re_consec, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
